connect4_board_ctrl: RTL
========================

// Module: connect4_board_ctrl
// PURPOSE
//  Board-state owner and win checker directly downstream of the column position calculator.
//  Accepts a 5-bit cell index (row*4+col on a 4x4 board; 5'b11111 = no cell) on each rising edge of move_valid.
//  Places the current player's token in two 16-bit occupancy masks, then checks that player's rows, columns and diagonals.
//  Reports win or draw, then alternates the turn. Outputs drive the display and LED status logic.
// PARAMETERS
//  NUM_CELLS   16   board cells; fixed 4x4, index = row*4 + col
//  NUM_LINES   10   winning lines checked: 4 rows, 4 columns, diagonal, anti-diagonal
// PORTS
//  clk             in   1   system clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  move_valid      in   1   level from upstream enable; a move is sampled on its 0->1 edge only
//  cell_index      in   5   cell to fill; 5'b11111 or >15 = invalid
//  new_game        in   1   synchronous clear, any state
//  board_a         out  16  player A occupancy mask, bit i = cell i
//  board_b         out  16  player B occupancy mask
//  current_player  out  1   0 = A to move, 1 = B to move
//  busy            out  1   high in PLACE/CHECK
//  move_ack        out  1   1-cycle pulse: accepted move fully evaluated
//  move_err        out  1   1-cycle pulse: move rejected
//  winner          out  2   00 none, 01 A, 10 B; held until new_game/reset
//  draw            out  1   board full, no winner; held
//  game_over       out  1   winner!=0 | draw
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, boards cleared, player A, state IDLE, edge register cleared.
//  - Edge detect: mv_rise = move_valid & ~move_valid_q. A held level never produces a second move.
//  - FSM states: IDLE, PLACE, CHECK, DONE, OVER.
//  - IDLE + mv_rise:
//      - cell_index>15, target cell occupied in either mask, or game_over -> move_err next cycle; no state change; stay IDLE.
//      - Otherwise latch the index and go to PLACE.
//  - PLACE: set mover's mask bit; goto CHECK with line counter = 0.
//  - CHECK: one line per cycle, counter 0..9 (0-3 rows, 4-7 cols, 8 = cells 0,5,10,15, 9 = cells 3,6,9,12).
//      - Only the mover's mask is tested; a hit sets a sticky win flag.
//      - Always exactly 10 cycles; no early exit.
//  - DONE (1 cycle): move_ack=1.
//      - Win: winner = mover, goto OVER.
//      - Else if (board_a|board_b)==16'hFFFF: draw=1, goto OVER.
//      - Else toggle current_player, goto IDLE.
//  - Latency: mv_rise sampled in cycle N -> move_ack in cycle N+12.
//  - Boards update in cycle N+2; winner/draw are visible in cycle N+13.
//  - busy high from N+1 through N+11.
//  - mv_rise while busy, in DONE, or in OVER -> move_err pulse; board unchanged.
//  - OVER: holds boards, winner and draw; only new_game or reset leaves it.
//  - new_game: next cycle boards=0, player A, winner=0, draw=0, IDLE.
//      - Priority over every other input; aborts PLACE/CHECK mid-flight with no ack.
//  - move_ack and move_err are never high in the same cycle.
// CONFIGURATION
//  UNDO_EN defined:
//    - Adds input undo_req (1 bit, rising-edge detected).
//    - In IDLE with at least one move since new_game: clears the last placed cell's bit and toggles current_player back.
//      Effect visible next cycle; one level of undo only, so a second undo without an intervening move gives move_err.
//    - undo_req in any other state gives move_err.
//  UNDO_EN undefined: no undo_req port and no last-move register.
// TESTING
//  1. Reset, then pulse index 0 -> move_ack at N+12; board_a=16'h0001, board_b=0, current_player=1.
//  2. Moves A:0,B:4,A:1,B:5,A:2,B:6,A:3 -> last ack then winner=01, game_over=1; further move -> move_err, boards held.
//  3. Repeat an occupied index (5 after 5) -> move_err at N+1, no ack, player unchanged.
//     Index 5'b11111 -> move_err.
//  4. Hold move_valid high 20 cycles with index 2 -> exactly one ack; board bit 2 set once.
//  5. Fill the board with no line: A:0,B:1,A:2,B:3,A:5,B:4,A:7,B:6,A:9,B:8,A:11,B:10,A:12,B:13,A:14,B:15 -> draw=1, winner=00.
//  6. new_game during CHECK, and rst_n low mid-CHECK -> all outputs 0, no ack.
//     With UNDO_EN: move idx 3, then undo -> board_a=0, current_player=0.

Source files
------------

// File: rtl/connect4_board_ctrl.sv
// 4x4 connect-four board owner: places tokens, scans the 10 winning lines serially, reports win/draw.
// Optional UNDO_EN macro adds a single-level undo via undo_req.
module connect4_board_ctrl #(
    parameter int NUM_CELLS = 16,
    parameter int NUM_LINES = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 move_valid,
    input  logic [4:0]           cell_index,
    input  logic                 new_game,
`ifdef UNDO_EN
    input  logic                 undo_req,
`endif
    output logic [NUM_CELLS-1:0] board_a,
    output logic [NUM_CELLS-1:0] board_b,
    output logic                 current_player,
    output logic                 busy,
    output logic                 move_ack,
    output logic                 move_err,
    output logic [1:0]           winner,
    output logic                 draw,
    output logic                 game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_CHECK,
        S_DONE,
        S_OVER
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_CELLS-1:0]   board_a_q, board_a_d;
    logic [NUM_CELLS-1:0]   board_b_q, board_b_d;
    logic                   player_q, player_d;
    logic                   busy_q, busy_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   err_pend_q, err_pend_d;
    logic [1:0]             winner_q, winner_d;
    logic                   draw_q, draw_d;
    logic                   win_q, win_d;
    logic [3:0]             idx_q, idx_d;
    logic [3:0]             line_q, line_d;
    logic                   move_valid_q;
    logic                   mv_rise;
    logic                   move_bad;
    logic                   occupied;
    logic [NUM_CELLS-1:0]   mover_mask;
    logic [NUM_CELLS-1:0]   cur_line;
`ifdef UNDO_EN
    logic                   undo_req_q;
    logic                   undo_rise;
    logic [3:0]             last_idx_q, last_idx_d;
    logic                   last_valid_q, last_valid_d;
`endif

    // Lines 0-3 rows, 4-7 columns, 8 main diagonal, 9 anti-diagonal.
    function automatic logic [NUM_CELLS-1:0] line_mask(input logic [3:0] k);
        logic [NUM_CELLS-1:0] m;
        m = '0;
        if (k < 4'd4) begin
            m = 16'h000F << {k[1:0], 2'b00};
        end else if (k < 4'd8) begin
            m = 16'h1111 << k[1:0];
        end else if (k == 4'd8) begin
            m = 16'h8421;
        end else if (k == 4'd9) begin
            m = 16'h1248;
        end
        return m;
    endfunction

    assign mv_rise    = move_valid & ~move_valid_q;
    assign occupied   = (board_a_q[cell_index[3:0]] | board_b_q[cell_index[3:0]]);
    assign mover_mask = player_q ? board_b_q : board_a_q;
    assign cur_line   = line_mask(line_q);
`ifdef UNDO_EN
    assign undo_rise  = undo_req & ~undo_req_q;
`endif

    always_comb begin
        state_d    = state_q;
        board_a_d  = board_a_q;
        board_b_d  = board_b_q;
        player_d   = player_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        err_d      = err_pend_q;
        err_pend_d = 1'b0;
        winner_d   = winner_q;
        draw_d     = draw_q;
        win_d      = win_q;
        idx_d      = idx_q;
        line_d     = line_q;
        move_bad   = 1'b0;
`ifdef UNDO_EN
        last_idx_d   = last_idx_q;
        last_valid_d = last_valid_q;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef UNDO_EN
                if (undo_rise) begin
                    if (last_valid_q) begin
                        // Last mover is the opposite of the player now to move.
                        if (player_q) begin
                            board_a_d[last_idx_q] = 1'b0;
                        end else begin
                            board_b_d[last_idx_q] = 1'b0;
                        end
                        player_d     = ~player_q;
                        last_valid_d = 1'b0;
                    end else begin
                        move_bad = 1'b1;
                    end
                    if (mv_rise) begin
                        move_bad = 1'b1;
                    end
                end else
`endif
                if (mv_rise) begin
                    if ((cell_index > 5'(NUM_CELLS - 1)) || occupied || game_over) begin
                        move_bad = 1'b1;
                    end else begin
                        idx_d   = cell_index[3:0];
                        busy_d  = 1'b1;
                        state_d = S_PLACE;
                    end
                end
            end

            S_PLACE: begin
                if (player_q) begin
                    board_b_d[idx_q] = 1'b1;
                end else begin
                    board_a_d[idx_q] = 1'b1;
                end
                line_d  = '0;
                win_d   = 1'b0;
                state_d = S_CHECK;
`ifdef UNDO_EN
                last_idx_d   = idx_q;
                last_valid_d = 1'b1;
`endif
                move_bad = mv_rise;
            end

            S_CHECK: begin
                if ((mover_mask & cur_line) == cur_line) begin
                    win_d = 1'b1;
                end
                if (line_q == 4'(NUM_LINES - 1)) begin
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    line_d = line_q + 4'd1;
                end
                move_bad = mv_rise;
            end

            S_DONE: begin
                if (win_q) begin
                    winner_d = player_q ? 2'b10 : 2'b01;
                    state_d  = S_OVER;
                end else if (&(board_a_q | board_b_q)) begin
                    draw_d  = 1'b1;
                    state_d = S_OVER;
                end else begin
                    player_d = ~player_q;
                    state_d  = S_IDLE;
                end
                move_bad = mv_rise;
            end

            S_OVER: begin
                move_bad = mv_rise;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef UNDO_EN
        if (undo_rise && (state_q != S_IDLE)) begin
            move_bad = 1'b1;
        end
`endif

        // A reject landing on the ack cycle is deferred one cycle so the pulses never overlap.
        if (ack_d) begin
            err_pend_d = err_d | move_bad;
            err_d      = 1'b0;
        end else if (move_bad) begin
            err_d = 1'b1;
        end

        if (new_game) begin
            state_d    = S_IDLE;
            board_a_d  = '0;
            board_b_d  = '0;
            player_d   = 1'b0;
            busy_d     = 1'b0;
            ack_d      = 1'b0;
            err_d      = 1'b0;
            err_pend_d = 1'b0;
            winner_d   = 2'b00;
            draw_d     = 1'b0;
            win_d      = 1'b0;
            line_d     = '0;
`ifdef UNDO_EN
            last_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            board_a_q    <= '0;
            board_b_q    <= '0;
            player_q     <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            err_pend_q   <= 1'b0;
            winner_q     <= 2'b00;
            draw_q       <= 1'b0;
            win_q        <= 1'b0;
            idx_q        <= '0;
            line_q       <= '0;
            move_valid_q <= 1'b0;
`ifdef UNDO_EN
            undo_req_q   <= 1'b0;
            last_idx_q   <= '0;
            last_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            board_a_q    <= board_a_d;
            board_b_q    <= board_b_d;
            player_q     <= player_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            err_pend_q   <= err_pend_d;
            winner_q     <= winner_d;
            draw_q       <= draw_d;
            win_q        <= win_d;
            idx_q        <= idx_d;
            line_q       <= line_d;
            move_valid_q <= move_valid;
`ifdef UNDO_EN
            undo_req_q   <= undo_req;
            last_idx_q   <= last_idx_d;
            last_valid_q <= last_valid_d;
`endif
        end
    end

    assign board_a        = board_a_q;
    assign board_b        = board_b_q;
    assign current_player = player_q;
    assign busy           = busy_q;
    assign move_ack       = ack_q;
    assign move_err       = err_q;
    assign winner         = winner_q;
    assign draw           = draw_q;
    assign game_over      = (winner_q != 2'b00) | draw_q;

endmodule
